// File: rtl/param_regfile_if.sv
// Register file access bundle: one write port and two read ports.
`timescale 1ns/1ps
interface param_regfile_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  // Handshake: 'we' qualifies waddr/wdata for exactly one clk edge; there is
  // no ready, the register file always accepts. Read ports are unqualified
  // combinational lookups.
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr1;
  logic [WIDTH-1:0] rdata1;
  logic [AW-1:0]    raddr2;
  logic [WIDTH-1:0] rdata2;
  logic [7:0]       wr_count;

  modport master (
    output we, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2, wr_count
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2, wr_count
  );
endinterface

// File: rtl/param_regfile.sv
// NREGS x WIDTH register file, two async read ports, one sync write port.
// Optional same-cycle write-to-read bypass when REGFILE_WRITE_BYPASS_EN is defined.
`timescale 1ns/1ps
module param_regfile #(
  parameter int               WIDTH    = 32,
  parameter int               NREGS    = 32,
  parameter int               ZERO_REG = 1,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic           clk,
  input  logic           rst,
  param_regfile_if.slave bus
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [WIDTH-1:0] mem [NREGS];
  logic [7:0]       cnt;
  logic             zero_wr;
  logic             commit;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;

  // Writes aimed at a hardwired-zero register 0 are dropped and not counted.
  assign zero_wr = (ZERO_REG != 0) && (bus.waddr == '0);
  assign commit  = bus.we && !zero_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= RST_VAL;
    end else if (commit) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (commit && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    rd1 = mem[bus.raddr1];
    rd2 = mem[bus.raddr2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (bus.we && !rst && !zero_wr && (bus.raddr1 == bus.waddr)) rd1 = bus.wdata;
    if (bus.we && !rst && !zero_wr && (bus.raddr2 == bus.waddr)) rd2 = bus.wdata;
`endif
    // Register 0 storage still exists but is masked on every read.
    if ((ZERO_REG != 0) && (bus.raddr1 == '0)) rd1 = '0;
    if ((ZERO_REG != 0) && (bus.raddr2 == '0)) rd2 = '0;
  end

  assign bus.rdata1   = rd1;
  assign bus.rdata2   = rd2;
  assign bus.wr_count = cnt;
endmodule
